// File: rtl/sram_responder.sv
// Dual-port word SRAM model behind a CPU-style inst/data SRAM interface, with a sticky access-error flag.
// Optional saturating error-event counter on err_cnt is enabled by defining SRAM_ERR_CNT_EN.
module sram_responder #(
   parameter int          ADDR_W = 16,
   parameter logic [31:0] BASE   = 32'h1C000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_we,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        err
`ifdef SRAM_ERR_CNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   // Span is kept 33 bits wide so the compare stays correct even when the array fills the 4 GiB space.
   localparam logic [32:0] SPAN = 33'(4) << ADDR_W;

   logic [31:0]       mem [0:(1<<ADDR_W)-1];

   logic [31:0]       inst_off;
   logic [31:0]       data_off;
   logic [ADDR_W-1:0] inst_idx;
   logic [ADDR_W-1:0] data_idx;
   logic              inst_in;
   logic              data_in;
   logic              inst_err;
   logic              data_err;
   logic              do_write;
   logic [31:0]       wr_word;
   logic              unused_bits;

   assign inst_off = inst_sram_addr - BASE;
   assign data_off = data_sram_addr - BASE;
   assign inst_idx = inst_off[ADDR_W+1:2];
   assign data_idx = data_off[ADDR_W+1:2];
   assign inst_in  = {1'b0, inst_off} < SPAN;
   assign data_in  = {1'b0, data_off} < SPAN;

   // A write-enable on the instruction port is a protocol error even for an in-range address.
   assign inst_err = inst_sram_en & (~inst_in | (|inst_sram_we));
   assign data_err = data_sram_en & ~data_in;
   assign do_write = ~reset & data_sram_en & data_in & (|data_sram_we);

   assign unused_bits = ^{inst_sram_wdata, inst_off[31:ADDR_W+2], inst_off[1:0],
                          data_off[31:ADDR_W+2], data_off[1:0]};

   always_comb begin
      wr_word = mem[data_idx];
      for (int i = 0; i < 4; i++) begin
         if (data_sram_we[i]) wr_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
      end
   end

   // Array has no reset; contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (do_write) mem[data_idx] <= wr_word;
   end

   // Read ports sample the array before this edge's write lands, giving read-first behaviour.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_sram_rdata <= 32'h0;
         data_sram_rdata <= 32'h0;
         err             <= 1'b0;
      end else begin
         if (inst_sram_en) inst_sram_rdata <= inst_in ? mem[inst_idx] : 32'h0;
         if (data_sram_en) data_sram_rdata <= data_in ? mem[data_idx] : 32'h0;
         if (inst_err || data_err) err <= 1'b1;
      end
   end

`ifdef SRAM_ERR_CNT_EN
   logic [16:0] cnt_sum;

   assign cnt_sum = {1'b0, err_cnt} + 17'(inst_err) + 17'(data_err);

   always_ff @(posedge clk) begin
      if (reset) err_cnt <= 16'h0;
      else       err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table for single-cycle traffic plus hand sequences
// for error, reset and aliasing corner cases.
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        err;
`ifdef SRAM_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   sram_responder dut (
      .clk             (clk),
      .reset           (reset),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .err             (err)
`ifdef SRAM_ERR_CNT_EN
      ,
      .err_cnt         (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        i_en;
      logic [31:0] i_addr;
      logic        d_en;
      logic [3:0]  d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        chk_d;
      logic [31:0] exp_d;
      logic [31:0] exp_i;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic cyc(input logic r,
                      input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                      input logic de, input logic [3:0] dw, input logic [31:0] da,
                      input logic [31:0] dwd);
      reset           = r;
      inst_sram_en    = ie;
      inst_sram_we    = iw;
      inst_sram_addr  = ia;
      inst_sram_wdata = 32'hFFFF_0000;
      data_sram_en    = de;
      data_sram_we    = dw;
      data_sram_addr  = da;
      data_sram_wdata = dwd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      //            i_en  i_addr         d_en  we    d_addr         wdata          chk   exp_d          exp_i
      vecs[0]  = '{1'b0, 32'h0,         1'b1, 4'hF, 32'h1C000100, 32'hDEADBEEF, 1'b0, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h1C000100, 32'h0,        1'b1, 32'hDEADBEEF, 32'h0};
      vecs[2]  = '{1'b0, 32'h0,         1'b1, 4'hF, 32'h1C000010, 32'h11223344, 1'b0, 32'h0,         32'h0};
      vecs[3]  = '{1'b0, 32'h0,         1'b1, 4'h5, 32'h1C000010, 32'hAABBCCDD, 1'b1, 32'h11223344, 32'h0};
      vecs[4]  = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h1C000010, 32'h0,        1'b1, 32'h11BB33DD, 32'h0};
      vecs[5]  = '{1'b0, 32'h0,         1'b1, 4'hF, 32'h1C000020, 32'h01234567, 1'b0, 32'h0,         32'h0};
      vecs[6]  = '{1'b1, 32'h1C000020,  1'b1, 4'hF, 32'h1C000020, 32'h55555555, 1'b1, 32'h01234567, 32'h01234567};
      vecs[7]  = '{1'b1, 32'h1C000020,  1'b1, 4'h0, 32'h1C000100, 32'h0,        1'b1, 32'hDEADBEEF, 32'h55555555};
      vecs[8]  = '{1'b1, 32'h1C000100,  1'b0, 4'hF, 32'h1C000100, 32'h77777777, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h1C000013, 32'h0,        1'b1, 32'h11BB33DD, 32'hDEADBEEF};
      vecs[10] = '{1'b0, 32'h0,         1'b1, 4'hF, 32'h1C03FFFC, 32'hA5A55A5A, 1'b0, 32'h0,         32'hDEADBEEF};
      vecs[11] = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h1C03FFFC, 32'h0,        1'b1, 32'hA5A55A5A, 32'hDEADBEEF};
      vecs[12] = '{1'b0, 32'h0,         1'b1, 4'hF, 32'h1C000040, 32'hCAFEF00D, 1'b0, 32'h0,         32'hDEADBEEF};
      vecs[13] = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h1C000040, 32'h0,        1'b1, 32'hCAFEF00D, 32'hDEADBEEF};
      vecs[14] = '{1'b0, 32'h0,         1'b0, 4'h0, 32'h1C000100, 32'h0,        1'b1, 32'hCAFEF00D, 32'hDEADBEEF};
      vecs[15] = '{1'b0, 32'h0,         1'b0, 4'hF, 32'h1C000010, 32'h0,        1'b1, 32'hCAFEF00D, 32'hDEADBEEF};
      vecs[16] = '{1'b0, 32'h0,         1'b0, 4'h0, 32'h1BFFFFFC, 32'h0,        1'b1, 32'hCAFEF00D, 32'hDEADBEEF};

      cyc(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      check("reset_inst_rdata", inst_sram_rdata, 32'h0);
      check("reset_data_rdata", data_sram_rdata, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);

      for (int i = 0; i < 17; i++) begin
         cyc(1'b0, vecs[i].i_en, 4'h0, vecs[i].i_addr,
             vecs[i].d_en, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
         if (vecs[i].chk_d) check($sformatf("vec%0d_data", i), data_sram_rdata, vecs[i].exp_d);
         check($sformatf("vec%0d_inst", i), inst_sram_rdata, vecs[i].exp_i);
         check($sformatf("vec%0d_err", i), {31'h0, err}, 32'h0);
      end

      // Address just below BASE wraps to a huge offset and must be rejected.
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1BFFFFFC, 32'h0);
      check("below_base_rdata", data_sram_rdata, 32'h0);
      check("below_base_err", {31'h0, err}, 32'h1);
`ifdef SRAM_ERR_CNT_EN
      check("below_base_cnt", {16'h0, err_cnt}, 32'h1);
`endif
      idle();
      check("err_sticky", {31'h0, err}, 32'h1);
      check("oor_hold_rdata", data_sram_rdata, 32'h0);

      // Reset during a write: the write must be suppressed and no read data loaded.
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h1C000040, 32'h13572468);
      cyc(1'b1, 1'b1, 4'h0, 32'h1C000040, 1'b1, 4'hF, 32'h1C000100, 32'h0BADF00D);
      check("rst_mid_data_rdata", data_sram_rdata, 32'h0);
      check("rst_mid_inst_rdata", inst_sram_rdata, 32'h0);
      check("rst_mid_err", {31'h0, err}, 32'h0);
`ifdef SRAM_ERR_CNT_EN
      check("rst_mid_cnt", {16'h0, err_cnt}, 32'h0);
`endif
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1C000100, 32'h0);
      check("rst_no_write", data_sram_rdata, 32'hDEADBEEF);
      cyc(1'b0, 1'b1, 4'h0, 32'h1C000040, 1'b0, 4'h0, 32'h0, 32'h0);
      check("pre_rst_write_kept", inst_sram_rdata, 32'h13572468);

      // Write one past the top would alias word 0 if the range check were missing.
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h1C000000, 32'h600DCAFE);
      check("top_pre_err", {31'h0, err}, 32'h0);
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h1C040000, 32'h12345678);
      check("top_oor_rdata", data_sram_rdata, 32'h0);
      check("top_oor_err", {31'h0, err}, 32'h1);
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1C000000, 32'h0);
      check("top_oor_no_write", data_sram_rdata, 32'h600DCAFE);

      // Instruction port: out-of-range read, then a write attempt.
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 4'h0, 32'h1C000100, 1'b0, 4'h0, 32'h0, 32'h0);
      check("inst_read", inst_sram_rdata, 32'hDEADBEEF);
      cyc(1'b0, 1'b1, 4'h0, 32'h1C040000, 1'b0, 4'h0, 32'h0, 32'h0);
      check("inst_oor_rdata", inst_sram_rdata, 32'h0);
      check("inst_oor_err", {31'h0, err}, 32'h1);

      cyc(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 4'h2, 32'h1C000100, 1'b0, 4'h0, 32'h0, 32'h0);
      check("inst_we_err", {31'h0, err}, 32'h1);
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1C000100, 32'h0);
      check("inst_we_no_write", data_sram_rdata, 32'hDEADBEEF);

`ifdef SRAM_ERR_CNT_EN
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, 4'h0, 32'h00000000, 1'b1, 4'h0, 32'hFFFFFFFC, 32'h0);
      check("cnt_both_ports", {16'h0, err_cnt}, 32'h2);
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1C040000, 32'h0);
      check("cnt_single", {16'h0, err_cnt}, 32'h3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the word-address width; the array holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h1C000000, the byte address that maps to word 0.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port inst_sram_en  in  1  instruction-port access request.
REQ-006 SHALL have port inst_sram_we  in  4  instruction-port byte write enables; treated as an error if nonzero.
REQ-007 SHALL have port inst_sram_addr  in  32  instruction byte address.
REQ-008 SHALL have port inst_sram_wdata  in  32  ignored.
REQ-009 SHALL have port inst_sram_rdata  out  32  registered instruction read data.
REQ-010 SHALL have port data_sram_en  in  1  data-port access request.
REQ-011 SHALL have port data_sram_we  in  4  data-port byte write enables; bit i controls byte lane [8i+7:8i].
REQ-012 SHALL have port data_sram_addr  in  32  data byte address.
REQ-013 SHALL have port data_sram_wdata  in  32  data-port write data.
REQ-014 SHALL have port data_sram_rdata  out  32  registered data read data.
REQ-015 SHALL have port err  out  1  sticky access-error flag.

Function
REQ-016 SHALL form the word index as (addr - BASE) >> 2; addr[1:0] ignored.
REQ-017 SHALL treat an access as in range iff (addr - BASE) < 4*2^ADDR_W, using unsigned 32-bit arithmetic, so addresses below BASE wrap and count as out of range.
REQ-018 SHALL, for a cycle with inst_sram_en=1 and an in-range address, load inst_sram_rdata with the addressed word at the next edge; read latency is exactly 1 cycle.
REQ-019 SHALL, when an en input is 0, hold that port's rdata unchanged.
REQ-020 SHALL never write the array from the instruction port.
REQ-021 SHALL, for data_sram_en=1, an in-range address and we!=0, update only the enabled byte lanes at the edge.
REQ-022 SHALL, on a data write cycle, load data_sram_rdata with the pre-write word (read-first).
REQ-023 SHALL, when the instruction port reads the same word the data port writes in the same cycle, return the pre-write word on inst_sram_rdata.
REQ-024 SHALL, for any enabled out-of-range access, load that port's rdata with 32'h0 and perform no array write.
REQ-025 SHALL set err=1 at the edge following any enabled out-of-range access, or any cycle with inst_sram_en=1 and inst_sram_we!=0.
REQ-026 SHALL hold err at 1 until reset.
REQ-027 SHALL serve both ports independently in the same cycle with no stalls or back-pressure.

Reset
REQ-028 SHALL, on a reset edge, clear inst_sram_rdata, data_sram_rdata and err to 0.
REQ-029 SHALL NOT clear or modify array contents on reset.
REQ-030 SHALL give reset priority over accesses: requests in a reset cycle perform no write and load no read data.

Configuration
REQ-031 SHALL, with macro SRAM_ERR_CNT_EN defined, add output err_cnt  out  16: a saturating count of error events, reset to 0, +1 per error cycle, +2 when both ports err in the same cycle, holding at 16'hFFFF.
REQ-032 SHALL, without SRAM_ERR_CNT_EN, have no err_cnt port and no counter logic.

Verification
REQ-033 SHALL check: data write 0x1C000100, we=4'hF, wdata=0xDEADBEEF; next cycle data read 0x1C000100 -> data_sram_rdata=0xDEADBEEF one cycle later.
REQ-034 SHALL check: word at 0x1C000010 = 0x11223344; write we=4'b0101, wdata=0xAABBCCDD -> subsequent read returns 0x11BB33DD.
REQ-035 SHALL check: same-cycle inst read and data write (0x55555555) to 0x1C000020, old word 0x01234567 -> inst_sram_rdata=0x01234567 and data_sram_rdata=0x01234567; later read returns 0x55555555.
REQ-036 SHALL check: data read 0x1BFFFFFC -> data_sram_rdata=0, err=1 next cycle; with SRAM_ERR_CNT_EN, err_cnt=1.
REQ-037 SHALL check: reset asserted mid-write stream -> no write in the reset cycle; rdata=0, err=0; array keeps prior data on a later read.
REQ-038 SHALL check: en=0 for 3 cycles after a read of 0xCAFEF00D -> rdata stays 0xCAFEF00D.
